// File: rtl/io_input_responder_if.sv
// io_input_responder_if
// Handshake between the core's ecall input stall logic and the input responder.
//   req_valid  : core -> responder, level, high while the core waits for input
//   req_kind   : core -> responder, 0 = read integer, 1 = read test case
//   resp_valid : responder -> core, one-cycle pulse qualifying resp_data
//   resp_data  : responder -> core, captured value, zero-extended to 32 bits
//   busy       : responder -> core, high whenever a request is in progress
//   wait_kind  : responder -> core, req_kind latched when the request was accepted
`timescale 1ns/1ps
interface io_input_responder_if;
    logic        req_valid;
    logic        req_kind;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        busy;
    logic        wait_kind;

    modport master (
        output req_valid,
        output req_kind,
        input  resp_valid,
        input  resp_data,
        input  busy,
        input  wait_kind
    );

    modport slave (
        input  req_valid,
        input  req_kind,
        output resp_valid,
        output resp_data,
        output busy,
        output wait_kind
    );
endinterface

// File: rtl/io_input_responder.sv
// io_input_responder
// Answers the core's input ecalls. It lights the wait LED and waits for the
// confirm button to be released and then pressed cleanly. On that press it
// returns the registered switch value (kind 0) or the test-case selector
// (kind 1) with a one-cycle valid pulse.
// Ports:
//   clk            : CPU clock
//   reset          : asynchronous, active-low reset
//   bus            : request/response handshake (slave side)
//   confirm_button : raw asynchronous pushbutton, active high
//   switch_in      : raw switch bank
//   test_number    : raw test-case selector switches
//   wait_led       : high while waiting for the operator's release/press
`timescale 1ns/1ps
module io_input_responder #(
    parameter int DEBOUNCE_CYCLES = 230000,
    parameter int DATA_W          = 16,
    parameter int CASE_W          = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    io_input_responder_if.slave   bus,
    input  logic                  confirm_button,
    input  logic [DATA_W-1:0]     switch_in,
    input  logic [CASE_W-1:0]     test_number,
    output logic                  wait_led
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RELEASE,
        WAIT_PRESS,
        RESPOND,
        WAIT_DROP
    } state_t;

    state_t            state;
    state_t            state_next;

    logic              btn_meta;
    logic              btn_sync;
    logic [CNT_W-1:0]  deb_cnt;
    logic              btn_level;
    logic              btn_level_q;
    logic              press_evt;

    logic [DATA_W-1:0] switch_reg;
    logic [CASE_W-1:0] case_reg;

    logic              accept;
    logic              capture;
    logic [31:0]       resp_data_r;
    logic              wait_kind_r;

    // The level only moves once the synchronized button has disagreed with it
    // for DEBOUNCE_CYCLES consecutive cycles. Any agreement restarts the count,
    // so the counter can never run past CNT_LAST.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_meta    <= 1'b0;
            btn_sync    <= 1'b0;
            deb_cnt     <= '0;
            btn_level   <= 1'b0;
            btn_level_q <= 1'b0;
        end else begin
            btn_meta    <= confirm_button;
            btn_sync    <= btn_meta;
            btn_level_q <= btn_level;
            if (btn_sync == btn_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == CNT_LAST) begin
                btn_level <= btn_sync;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + CNT_W'(1);
            end
        end
    end

    assign press_evt = btn_level & ~btn_level_q;

    // The capture uses these registered copies. A switch change on the press
    // cycle therefore returns the value seen one edge earlier.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            switch_reg <= '0;
            case_reg   <= '0;
        end else begin
            switch_reg <= switch_in;
            case_reg   <= test_number;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A request is only completed by a press that starts after a release seen
    // in WAIT_RELEASE. A button held across requests cannot answer the new one.
    // A dropped request aborts while waiting and takes priority over a press.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    accept     = 1'b1;
                    state_next = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                if (!bus.req_valid) begin
                    state_next = IDLE;
                end else if (!btn_level) begin
                    state_next = WAIT_PRESS;
                end
            end
            WAIT_PRESS: begin
                if (!bus.req_valid) begin
                    state_next = IDLE;
                end else if (press_evt) begin
                    capture    = 1'b1;
                    state_next = RESPOND;
                end
            end
            RESPOND: begin
                state_next = WAIT_DROP;
            end
            WAIT_DROP: begin
                if (!bus.req_valid) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_data_r <= '0;
            wait_kind_r <= 1'b0;
        end else begin
            if (accept) begin
                wait_kind_r <= bus.req_kind;
            end
            if (capture) begin
                resp_data_r <= wait_kind_r ? 32'(case_reg) : 32'(switch_reg);
            end
        end
    end

    assign bus.resp_valid = (state == RESPOND);
    assign bus.resp_data  = resp_data_r;
    assign bus.busy       = (state != IDLE);
    assign bus.wait_kind  = wait_kind_r;
    assign wait_led       = (state == WAIT_RELEASE) || (state == WAIT_PRESS);

endmodule

// File: tb/tb_io_input_responder.sv
// tb_io_input_responder
// Self-checking bench for io_input_responder with a short debounce window.
// A transaction-level reference model runs alongside the DUT. It tracks the
// button as a sample history and the request as a set of progress flags. All
// outputs are compared every cycle. Directed scenarios add fixed-value checks.
`timescale 1ns/1ps
module tb_io_input_responder;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        confirm_button = 1'b0;
    logic [15:0] switch_in = '0;
    logic [2:0]  test_number = '0;
    logic        wait_led;

    io_input_responder_if bus();

    io_input_responder #(
        .DEBOUNCE_CYCLES(DEB),
        .DATA_W(16),
        .CASE_W(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .confirm_button(confirm_button),
        .switch_in(switch_in),
        .test_number(test_number),
        .wait_led(wait_led)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int pulse_count = 0;
    int cycle_no = 0;
    int last_pulse_cycle = 0;

    // Reference model state
    bit          raw_hist[$];
    bit          sync_hist[$];
    bit          m_deb;
    bit          m_deb_prev;
    logic [15:0] m_sw;
    logic [2:0]  m_case;
    bit          m_active;
    bit          m_armed;
    bit          m_done;
    bit          m_pulse;
    bit          m_kind;
    logic [31:0] m_data;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, actual, expected, cycle_no);
        end
    endtask

    task automatic applyStimulus(input bit rv, input bit rk, input bit btn,
                                 input logic [15:0] sw, input logic [2:0] tn);
        bus.req_valid  = rv;
        bus.req_kind   = rk;
        confirm_button = btn;
        switch_in      = sw;
        test_number    = tn;
    endtask

    task automatic model_reset();
        raw_hist.delete();
        sync_hist.delete();
        m_deb = 0; m_deb_prev = 0;
        m_sw = '0; m_case = '0;
        m_active = 0; m_armed = 0; m_done = 0; m_pulse = 0; m_kind = 0;
        m_data = '0;
    endtask

    // Called just after a rising edge, while the inputs still hold the values
    // that edge sampled.
    task automatic model_edge();
        bit sync_now;
        bit press;
        bit flip;
        if (!reset) begin
            model_reset();
            return;
        end
        sync_now = (raw_hist.size() == 2) ? raw_hist[0] : 1'b0;
        press    = m_deb && !m_deb_prev;

        if (!m_active) begin
            if (bus.req_valid) begin
                m_active = 1; m_armed = 0; m_done = 0; m_kind = bus.req_kind;
            end
        end else if (m_done) begin
            if (m_pulse) m_pulse = 0;
            else if (!bus.req_valid) m_active = 0;
        end else if (!bus.req_valid) begin
            m_active = 0;
        end else if (!m_armed) begin
            if (!m_deb) m_armed = 1;
        end else if (press) begin
            m_data  = m_kind ? 32'(m_case) : 32'(m_sw);
            m_done  = 1;
            m_pulse = 1;
        end

        // The level flips once the last DEB synchronized samples all disagree with it.
        sync_hist.push_back(sync_now);
        if (sync_hist.size() > DEB) void'(sync_hist.pop_front());
        flip = (sync_hist.size() == DEB);
        foreach (sync_hist[i]) if (sync_hist[i] == m_deb) flip = 0;
        m_deb_prev = m_deb;
        if (flip) m_deb = !m_deb;

        raw_hist.push_back(confirm_button);
        if (raw_hist.size() > 2) void'(raw_hist.pop_front());
        m_sw   = switch_in;
        m_case = test_number;
    endtask

    task automatic compare_model();
        checkOutput("resp_valid", 32'(bus.resp_valid), 32'(m_pulse));
        checkOutput("resp_data",  bus.resp_data, m_data);
        checkOutput("busy",       32'(bus.busy), 32'(m_active));
        checkOutput("wait_led",   32'(wait_led), 32'(m_active && !m_done));
        checkOutput("wait_kind",  32'(bus.wait_kind), 32'(m_kind));
    endtask

    task automatic step_cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cycle_no++;
        if (bus.resp_valid === 1'b1) begin
            pulse_count++;
            last_pulse_cycle = cycle_no;
        end
        compare_model();
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step_cycle();
    endtask

    task automatic check_reset_zero(input string tag);
        checkOutput({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
        checkOutput({tag, "_resp_data"},  bus.resp_data, 32'd0);
        checkOutput({tag, "_busy"},       32'(bus.busy), 32'd0);
        checkOutput({tag, "_wait_led"},   32'(wait_led), 32'd0);
        checkOutput({tag, "_wait_kind"},  32'(bus.wait_kind), 32'd0);
    endtask

    // Asynchronous reset pulse issued between clock edges.
    task automatic pulse_reset(input string tag);
        reset = 1'b0;
        #1;
        model_reset();
        check_reset_zero(tag);
        step_cycle();
        reset = 1'b1;
    endtask

    initial begin
        int p0;
        int c0;
        bit bounce_pat[14] = '{1,1,1,0,1,1,0,0,0,0,0,0,0,0};
        bit press_pat[14]  = '{1,1,1,1,1,1,0,0,0,0,0,0,0,0};
        bit btn;
        int run_left;

        applyStimulus(0, 0, 0, 16'h0000, 3'b000);
        model_reset();
        #2 reset = 1'b0;
        #1 check_reset_zero("reset");
        step_n(2);
        reset = 1'b1;
        step_n(2);

        // Read integer
        applyStimulus(1, 0, 0, 16'hA5C3, 3'b000);
        step_cycle();
        checkOutput("int_wait_led_first", 32'(wait_led), 32'd1);
        step_cycle();
        p0 = pulse_count;
        c0 = cycle_no;
        confirm_button = 1'b1;
        step_n(12);
        checkOutput("int_pulses", 32'(pulse_count - p0), 32'd1);
        checkOutput("int_latency", 32'(last_pulse_cycle - c0), 32'd7);
        checkOutput("int_data", bus.resp_data, 32'h0000A5C3);
        applyStimulus(0, 0, 0, 16'hA5C3, 3'b000);
        step_cycle();
        checkOutput("int_idle_busy", 32'(bus.busy), 32'd0);
        step_n(10);

        // Read test case
        applyStimulus(1, 1, 0, 16'h0000, 3'b101);
        step_n(2);
        checkOutput("case_wait_kind", 32'(bus.wait_kind), 32'd1);
        p0 = pulse_count;
        confirm_button = 1'b1;
        step_n(12);
        checkOutput("case_pulses", 32'(pulse_count - p0), 32'd1);
        checkOutput("case_data", bus.resp_data, 32'h00000005);
        applyStimulus(0, 0, 0, 16'h0000, 3'b000);
        step_n(10);

        // Button held across the request
        confirm_button = 1'b1;
        step_n(10);
        applyStimulus(1, 0, 1, 16'h1234, 3'b000);
        p0 = pulse_count;
        step_n(15);
        checkOutput("held_pulses", 32'(pulse_count - p0), 32'd0);
        checkOutput("held_wait_led", 32'(wait_led), 32'd1);
        confirm_button = 1'b0;
        step_n(8);
        confirm_button = 1'b1;
        step_n(12);
        checkOutput("held_after_pulses", 32'(pulse_count - p0), 32'd1);
        checkOutput("held_data", bus.resp_data, 32'h00001234);
        applyStimulus(0, 0, 0, 16'h0000, 3'b000);
        step_n(10);

        // Bounce rejection
        applyStimulus(1, 0, 0, 16'hBEEF, 3'b000);
        step_n(3);
        p0 = pulse_count;
        foreach (bounce_pat[i]) begin
            confirm_button = bounce_pat[i];
            step_cycle();
        end
        checkOutput("bounce_pulses", 32'(pulse_count - p0), 32'd0);
        foreach (press_pat[i]) begin
            confirm_button = press_pat[i];
            step_cycle();
        end
        checkOutput("bounce_press_pulses", 32'(pulse_count - p0), 32'd1);
        checkOutput("bounce_data", bus.resp_data, 32'h0000BEEF);
        applyStimulus(0, 0, 0, 16'h0000, 3'b000);
        step_n(10);

        // Abort while waiting for the press
        applyStimulus(1, 0, 0, 16'h1111, 3'b000);
        step_n(3);
        p0 = pulse_count;
        bus.req_valid = 1'b0;
        step_cycle();
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        step_n(3);
        checkOutput("abort_pulses", 32'(pulse_count - p0), 32'd0);
        checkOutput("abort_data", bus.resp_data, 32'h0000BEEF);

        // Reset in the middle of a debounce
        applyStimulus(1, 0, 0, 16'h2222, 3'b000);
        step_n(3);
        confirm_button = 1'b1;
        step_n(3);
        applyStimulus(0, 0, 0, 16'h2222, 3'b000);
        pulse_reset("midreset");
        step_cycle();
        checkOutput("midreset_idle_busy", 32'(bus.busy), 32'd0);
        step_n(4);

        // Randomized traffic against the reference model
        btn = 0;
        run_left = 1;
        for (int i = 0; i < 4000; i++) begin
            if (--run_left == 0) begin
                btn = !btn;
                run_left = $urandom_range(1, 8);
            end
            confirm_button = btn;
            if ($urandom_range(0, 29) == 0) bus.req_valid = !bus.req_valid;
            if (!bus.req_valid) bus.req_kind = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) switch_in = 16'($urandom);
            if ($urandom_range(0, 3) == 0) test_number = 3'($urandom);
            if ($urandom_range(0, 999) == 0) pulse_reset("rand_reset");
            else step_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
